// File: rtl/counter_pnb.sv
// counter_pnb: N-bit free-running binary up-counter with synchronous,
// active-high clear. Counts modulo 2^N with no enable and no saturation.
// Optional build macro COUNTER_PNB_TC_EN adds the tc output. tc is high
// exactly while q is all ones.
// N must lie in 1..32.
module counter_pnb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  output logic [N-1:0] q
`ifdef COUNTER_PNB_TC_EN
  ,
  output logic         tc
`endif
);

  logic [N-1:0] r_q;
  logic [N-1:0] w_q_next;

  // Next count: wraps from all-ones to zero through natural N-bit overflow
  assign w_q_next = r_q + N'(1);

  // Count register: the clear takes priority and is sampled only at the clock edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign q = r_q;

`ifdef COUNTER_PNB_TC_EN
  // Terminal count decodes the registered value only, so it tracks q in the same cycle
  assign tc = &r_q;
`endif

endmodule

// File: tb/tb_counter_pnb.sv
// Scoreboard bench for counter_pnb.
// Three instances (N = 2, 4, 6) run side by side on one clock, and each has
// its own reset. The stimulus drives the resets between clock edges and
// pushes the hand-computed counts that are expected after the next edge.
// The monitor pops one entry after every rising edge and compares it.
module tb_counter_pnb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst2 = 1'b1;
  logic       rst4 = 1'b1;
  logic       rst6 = 1'b1;
  logic [1:0] q2;
  logic [3:0] q4;
  logic [5:0] q6;

`ifdef COUNTER_PNB_TC_EN
  logic tc2, tc4, tc6;
  counter_pnb #(.N(2)) u_c2 (.clk(clk), .reset(rst2), .q(q2), .tc(tc2));
  counter_pnb #(.N(4)) u_c4 (.clk(clk), .reset(rst4), .q(q4), .tc(tc4));
  counter_pnb #(.N(6)) u_c6 (.clk(clk), .reset(rst6), .q(q6), .tc(tc6));
`else
  counter_pnb #(.N(2)) u_c2 (.clk(clk), .reset(rst2), .q(q2));
  counter_pnb #(.N(4)) u_c4 (.clk(clk), .reset(rst4), .q(q4));
  counter_pnb #(.N(6)) u_c6 (.clk(clk), .reset(rst6), .q(q6));
`endif

  typedef struct packed {
    logic [15:0] id;
    logic [1:0]  q2;
    logic [3:0]  q4;
    logic [5:0]  q6;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  // Monitor: one expected entry is due after each rising edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q2", int'(e.id), 32'(q2), 32'(e.q2));
        chk("q4", int'(e.id), 32'(q4), 32'(e.q4));
        chk("q6", int'(e.id), 32'(q6), 32'(e.q6));
`ifdef COUNTER_PNB_TC_EN
        chk("tc2", int'(e.id), 32'(tc2), 32'(e.q2 == 2'b11));
        chk("tc4", int'(e.id), 32'(tc4), 32'(e.q4 == 4'hF));
        chk("tc6", int'(e.id), 32'(tc6), 32'(e.q6 == 6'h3F));
`endif
      end
    end
  end

  int vec_id = 0;

  // Set the resets between edges. A glitch pulses rst2 high and back low
  // again before the edge, and that pulse must leave q2 unaffected.
  task automatic drive(input logic r2, input logic r4, input logic r6,
                       input logic glitch, input logic [1:0] e2,
                       input logic [3:0] e4, input logic [5:0] e6);
    exp_t e;
    @(negedge clk);
    rst4 = r4;
    rst6 = r6;
    if (glitch) begin
      rst2 = 1'b1;
      #2;
    end
    rst2 = r2;
    e.id = 16'(vec_id);
    e.q2 = e2;
    e.q4 = e4;
    e.q6 = e6;
    sb.push_back(e);
    vec_id++;
  endtask

  logic [1:0] m2;
  logic [3:0] m4;
  logic [5:0] m6;

  initial begin
    // Hold reset for two edges, then release all three counters
    drive(1, 1, 1, 0, 2'd0, 4'd0,  6'd0);
    drive(1, 1, 1, 0, 2'd0, 4'd0,  6'd0);
    drive(0, 0, 0, 0, 2'd1, 4'd1,  6'd1);
    drive(0, 0, 0, 0, 2'd2, 4'd2,  6'd2);
    drive(0, 0, 0, 0, 2'd3, 4'd3,  6'd3);
    drive(0, 0, 0, 0, 2'd0, 4'd4,  6'd4);   // q2 wraps 3 -> 0
    drive(0, 0, 0, 0, 2'd1, 4'd5,  6'd5);
    drive(0, 0, 0, 0, 2'd2, 4'd6,  6'd6);
    drive(0, 0, 0, 0, 2'd3, 4'd7,  6'd7);
    // Clear q2 at 3 for two edges while the other counters continue
    drive(1, 0, 0, 0, 2'd0, 4'd8,  6'd8);
    drive(1, 0, 0, 0, 2'd0, 4'd9,  6'd9);
    drive(0, 0, 0, 0, 2'd1, 4'd10, 6'd10);
    drive(0, 0, 0, 1, 2'd2, 4'd11, 6'd11);  // pulse on rst2 between edges
    drive(0, 0, 0, 0, 2'd3, 4'd12, 6'd12);
    drive(0, 0, 0, 1, 2'd0, 4'd13, 6'd13);
    drive(0, 0, 0, 0, 2'd1, 4'd14, 6'd14);
    drive(0, 0, 0, 0, 2'd2, 4'd15, 6'd15);  // q4 reaches all ones
    // Clear q4 at 15 while q6 moves on from 15 to 16
    drive(0, 1, 0, 0, 2'd3, 4'd0,  6'd16);
    drive(0, 0, 0, 0, 2'd0, 4'd1,  6'd17);
    drive(0, 0, 0, 0, 2'd1, 4'd2,  6'd18);

    // Free run long enough to wrap q4 and q6 (q6 goes through 63 -> 0)
    m2 = 2'd1;
    m4 = 4'd2;
    m6 = 6'd18;
    for (int i = 0; i < 60; i++) begin
      m2 = m2 + 2'd1;
      m4 = m4 + 4'd1;
      m6 = m6 + 6'd1;
      drive(0, 0, 0, 0, m2, m4, m6);
    end

    // Clear only q6, then count 23 edges: q6 must reach 6'b010111
    m2 = m2 + 2'd1;
    m4 = m4 + 4'd1;
    drive(0, 0, 1, 0, m2, m4, 6'd0);
    for (int i = 1; i <= 23; i++) begin
      m2 = m2 + 2'd1;
      m4 = m4 + 4'd1;
      drive(0, 0, 0, 0, m2, m4, 6'(i));
    end

    // Final clear of everything, then one count
    drive(1, 1, 1, 0, 2'd0, 4'd0, 6'd0);
    drive(0, 0, 0, 0, 2'd1, 4'd1, 6'd1);

    // Let the monitor drain the queue, with a bounded wait
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
